// File: rtl/draw_write_sched.sv
// -----------------------------------------------------------------------------
// draw_write_sched
//
// Sequences paired framebuffer writes on a dual-port memory. Every beat writes
// one even/odd pixel pair: port A gets {ptr,0}, port B gets {ptr,1}. Two
// requesters share the memory: a region-clear channel (writes CLEAR_VAL) and
// a draw channel (streams pixel pairs). Jobs are granted round-robin from
// IDLE, one at a time, and run to completion without preemption. A job whose
// range would run past the last pair is clipped to end on pair 2^PW-1.
//
// Ports
//   clk, reset            system clock; synchronous active-high reset
//   clr_req/base/len      clear job request (level, held until clr_ack)
//   clr_ack               one-cycle pulse: clear job accepted
//   drw_req/base/len      draw job request (level, held until drw_ack)
//   drw_ack               one-cycle pulse: draw job accepted
//   px_valid, px_a, px_b  incoming pixel pair (even, odd)
//   px_ready              pixel pair consumed this cycle
//   mem_ready             memory accepts a write this cycle
//   mem_we                write strobe for both ports
//   mem_addr_a/b          {ptr,0} / {ptr,1}
//   mem_din_a/b           write data, zero when not writing
//   busy                  any state other than IDLE
//   done                  one-cycle pulse, job finished
//   done_src              with done: 0 = clear, 1 = draw
//   clip                  with done: job length was clipped
// -----------------------------------------------------------------------------
module draw_write_sched #(
    parameter int unsigned   PW        = 13,
    parameter int unsigned   DW        = 8,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    input  logic [PW-1:0] clr_base,
    input  logic [PW-1:0] clr_len,
    output logic          clr_ack,
    input  logic          drw_req,
    input  logic [PW-1:0] drw_base,
    input  logic [PW-1:0] drw_len,
    output logic          drw_ack,
    input  logic          px_valid,
    input  logic [DW-1:0] px_a,
    input  logic [DW-1:0] px_b,
    output logic          px_ready,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic [PW:0]   mem_addr_a,
    output logic [PW:0]   mem_addr_b,
    output logic [DW-1:0] mem_din_a,
    output logic [DW-1:0] mem_din_b,
    output logic          busy,
    output logic          done,
    output logic          done_src,
    output logic          clip
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAW  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_rem;
    logic          r_last_draw;   // last granted channel; also the running job's source
    logic          r_clip;

    logic          w_idle;
    logic          w_grant_clr;
    logic          w_grant_drw;
    logic          w_grant;
    logic [PW-1:0] w_base;
    logic [PW-1:0] w_len;
    logic [PW:0]   w_end;
    logic          w_clip;
    logic [PW-1:0] w_room;
    logic [PW-1:0] w_eff_len;
    logic          w_beat;

    // ------------------------------------------------------------------
    // Arbitration: a lone request wins; on a tie the channel that did not
    // win last time is granted.
    // ------------------------------------------------------------------
    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_clr = w_idle & clr_req & (~drw_req | r_last_draw);
    assign w_grant_drw = w_idle & drw_req & (~clr_req | ~r_last_draw);
    assign w_grant     = w_grant_clr | w_grant_drw;

    assign w_base = w_grant_drw ? drw_base : clr_base;
    assign w_len  = w_grant_drw ? drw_len  : clr_len;

    // One extra bit so the end of the range can reach 2^PW without wrapping.
    assign w_end  = {1'b0, w_base} + {1'b0, w_len};
    assign w_clip = (w_end > {1'b1, {PW{1'b0}}});
    // 2^PW - base taken modulo 2^PW; exact whenever clipping, because a
    // clipped job always has base > 0 (len alone never exceeds 2^PW-1).
    assign w_room    = -w_base;
    assign w_eff_len = w_clip ? w_room : w_len;

    // ------------------------------------------------------------------
    // Next state and outputs. Strobes are masked while reset is high so a
    // reset cycle never commits an ack, write or done whose effect the
    // registers are about to discard.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        clr_ack     = 1'b0;
        drw_ack     = 1'b0;
        px_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_din_a   = '0;
        mem_din_b   = '0;
        done        = 1'b0;
        done_src    = 1'b0;
        clip        = 1'b0;

        case (r_state)
            S_IDLE: begin
                clr_ack = w_grant_clr & ~reset;
                drw_ack = w_grant_drw & ~reset;
                if (w_grant) begin
                    if (w_eff_len == '0) begin
                        w_state_nxt = S_FIN;
                    end else if (w_grant_drw) begin
                        w_state_nxt = S_DRAW;
                    end else begin
                        w_state_nxt = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                w_beat = mem_ready;
                mem_we = w_beat & ~reset;
                if (mem_we) begin
                    mem_din_a = CLEAR_VAL;
                    mem_din_b = CLEAR_VAL;
                end
            end
            S_DRAW: begin
                w_beat   = mem_ready & px_valid;
                mem_we   = w_beat & ~reset;
                px_ready = mem_we;
                if (mem_we) begin
                    mem_din_a = px_a;
                    mem_din_b = px_b;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
                done        = ~reset;
                done_src    = ~reset & r_last_draw;
                clip        = ~reset & r_clip;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The beat that consumes the final pair ends the job.
        if (w_beat && (r_rem == PW'(1))) begin
            w_state_nxt = S_FIN;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registered state is always updated with non-blocking
        // assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Job registers: latched on grant, stepped on each beat. Stalls simply
    // produce no beat, so pointer and count hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_rem       <= '0;
            r_last_draw <= 1'b1;   // clear wins the first tie after reset
            r_clip      <= 1'b0;
        end else if (w_grant) begin
            r_ptr       <= w_base;
            r_rem       <= w_eff_len;
            r_last_draw <= w_grant_drw;
            r_clip      <= w_clip;
        end else if (w_beat) begin
            r_ptr       <= r_ptr + PW'(1);
            r_rem       <= r_rem - PW'(1);
        end
    end

    assign mem_addr_a = {r_ptr, 1'b0};
    assign mem_addr_b = {r_ptr, 1'b1};
    assign busy       = ~w_idle;

endmodule

// File: tb/tb_draw_write_sched.sv
// -----------------------------------------------------------------------------
// tb_draw_write_sched
//
// Self-checking bench for draw_write_sched. A queue-based reference model
// runs every cycle and predicts all outputs from the current inputs; on top
// of that a table of jobs and several hand-written sequences check lengths,
// clipping, latency, arbitration order, stalls and reset mid-job.
// -----------------------------------------------------------------------------
module tb_draw_write_sched;

    localparam int PW = 13;
    localparam int DW = 8;
    localparam int PN = 1 << PW;   // number of pairs

    logic          clk = 1'b0;
    logic          reset;
    logic          clr_req;
    logic [PW-1:0] clr_base;
    logic [PW-1:0] clr_len;
    logic          clr_ack;
    logic          drw_req;
    logic [PW-1:0] drw_base;
    logic [PW-1:0] drw_len;
    logic          drw_ack;
    logic          px_valid;
    logic [DW-1:0] px_a;
    logic [DW-1:0] px_b;
    logic          px_ready;
    logic          mem_ready;
    logic          mem_we;
    logic [PW:0]   mem_addr_a;
    logic [PW:0]   mem_addr_b;
    logic [DW-1:0] mem_din_a;
    logic [DW-1:0] mem_din_b;
    logic          busy;
    logic          done;
    logic          done_src;
    logic          clip;

    draw_write_sched #(.PW(PW), .DW(DW), .CLEAR_VAL('0)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .clr_base   (clr_base),
        .clr_len    (clr_len),
        .clr_ack    (clr_ack),
        .drw_req    (drw_req),
        .drw_base   (drw_base),
        .drw_len    (drw_len),
        .drw_ack    (drw_ack),
        .px_valid   (px_valid),
        .px_a       (px_a),
        .px_b       (px_b),
        .px_ready   (px_ready),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr_a (mem_addr_a),
        .mem_addr_b (mem_addr_b),
        .mem_din_a  (mem_din_a),
        .mem_din_b  (mem_din_b),
        .busy       (busy),
        .done       (done),
        .done_src   (done_src),
        .clip       (clip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int t_ack    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change just after the rising edge; outputs are read on the
    // falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model. A job is a list of pair indices still to write;
    // a finished list means one done cycle follows.
    // ------------------------------------------------------------------
    int m_pairs[$];
    int m_ptr       = 0;
    int m_fin       = 0;
    int m_src       = 0;
    int m_clip      = 0;
    int m_last_draw = 1;

    always @(negedge clk) begin : model
        int e_ack_c, e_ack_d, e_we, e_pxr, e_done, e_src, e_clip, e_busy;
        int e_pair, e_din_a, e_din_b;
        int b, l, eff, dummy;
        e_ack_c = 0; e_ack_d = 0; e_we = 0; e_pxr = 0;
        e_done = 0; e_src = 0; e_clip = 0; e_din_a = 0; e_din_b = 0;
        e_busy = (m_fin != 0 || m_pairs.size() != 0) ? 1 : 0;
        e_pair = (m_pairs.size() != 0) ? m_pairs[0] : m_ptr;

        if (m_fin != 0) begin
            e_done = 1;
            e_src  = m_src;
            e_clip = m_clip;
        end else if (m_pairs.size() != 0) begin
            if (mem_ready && (m_src == 0 || px_valid)) begin
                e_we    = 1;
                e_pxr   = m_src;
                e_din_a = (m_src != 0) ? int'(px_a) : 0;
                e_din_b = (m_src != 0) ? int'(px_b) : 0;
            end
        end else begin
            if (clr_req && drw_req) begin
                e_ack_c = m_last_draw;
                e_ack_d = 1 - m_last_draw;
            end else begin
                e_ack_c = int'(clr_req);
                e_ack_d = int'(drw_req);
            end
        end

        if (!reset) begin
            check("model clr_ack",    32'(clr_ack),    e_ack_c);
            check("model drw_ack",    32'(drw_ack),    e_ack_d);
            check("model busy",       32'(busy),       e_busy);
            check("model mem_we",     32'(mem_we),     e_we);
            check("model px_ready",   32'(px_ready),   e_pxr);
            check("model mem_addr_a", 32'(mem_addr_a), 2 * e_pair);
            check("model mem_addr_b", 32'(mem_addr_b), 2 * e_pair + 1);
            check("model mem_din_a",  32'(mem_din_a),  e_din_a);
            check("model mem_din_b",  32'(mem_din_b),  e_din_b);
            check("model done",       32'(done),       e_done);
            check("model done_src",   32'(done_src),   e_src);
            check("model clip",       32'(clip),       e_clip);
        end

        if (reset) begin
            m_pairs.delete();
            m_fin = 0; m_ptr = 0; m_src = 0; m_clip = 0; m_last_draw = 1;
        end else if (m_fin != 0) begin
            m_fin = 0;
        end else if (m_pairs.size() != 0) begin
            if (e_we != 0) begin
                dummy = m_pairs.pop_front();
                m_ptr = (dummy + 1) % PN;
                if (m_pairs.size() == 0) m_fin = 1;
            end
        end else if (e_ack_c != 0 || e_ack_d != 0) begin
            b   = (e_ack_d != 0) ? int'(drw_base) : int'(clr_base);
            l   = (e_ack_d != 0) ? int'(drw_len)  : int'(clr_len);
            eff = (b + l > PN) ? PN - b : l;
            m_clip      = (b + l > PN) ? 1 : 0;
            m_src       = e_ack_d;
            m_last_draw = e_ack_d;
            m_ptr       = b;
            for (int i = 0; i < eff; i++) m_pairs.push_back(b + i);
            if (eff == 0) m_fin = 1;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic wait_ack(input int is_draw, input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (is_draw != 0) ? drw_ack : clr_ack;
            if (got) t_ack = cyc;
            tick();
        end
        check({name, " ack seen"}, 32'(got), 1);
    endtask

    task automatic wait_any_ack(output bit got, output bit is_d);
        got = 0;
        is_d = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (clr_ack || drw_ack) begin
                got = 1;
                is_d = drw_ack;
                t_ack = cyc;
            end
            tick();
        end
    endtask

    // Runs until done (bounded), counting writes and recording addresses.
    task automatic drain(input int budget, output int n, output int first_a, output int last_a,
                         output bit got, output int t_done, output bit src, output bit clp);
        n = 0; first_a = -1; last_a = -1; got = 0; t_done = 0; src = 0; clp = 0;
        for (int i = 0; i < budget && !got; i++) begin
            px_a = DW'($urandom);
            px_b = DW'($urandom);
            @(negedge clk);
            if (mem_we) begin
                if (n == 0) first_a = int'(mem_addr_a);
                last_a = int'(mem_addr_a);
                n++;
            end
            if (done) begin
                got = 1;
                t_done = cyc;
                src = done_src;
                clp = clip;
            end
            tick();
        end
    endtask

    typedef struct {
        int is_draw;
        int base;
        int len;
        int exp_n;
        int exp_clip;
        int exp_first_a;
        int exp_last_a;
    } job_vec_t;

    job_vec_t vecs[9];

    task automatic run_job(input job_vec_t v, input string name);
        int n, first_a, last_a, t_done;
        bit got, src, clp;
        if (v.is_draw != 0) begin
            drw_req = 1; drw_base = PW'(v.base); drw_len = PW'(v.len);
        end else begin
            clr_req = 1; clr_base = PW'(v.base); clr_len = PW'(v.len);
        end
        wait_ack(v.is_draw, name);
        clr_req = 0; drw_req = 0;
        // Latched values must not follow the inputs after ack.
        clr_base = PW'($urandom); clr_len = PW'($urandom);
        drw_base = PW'($urandom); drw_len = PW'($urandom);
        drain(v.exp_n + 20, n, first_a, last_a, got, t_done, src, clp);
        check({name, " done seen"}, 32'(got), 1);
        check({name, " writes"},    n,       v.exp_n);
        check({name, " first a"},   first_a, v.exp_first_a);
        check({name, " last a"},    last_a,  v.exp_last_a);
        if (got) begin
            check({name, " done_src"}, 32'(src), v.is_draw);
            check({name, " clip"},     32'(clp), v.exp_clip);
            check({name, " latency"},  t_done - t_ack, v.exp_n + 1);
        end
    endtask

    task automatic toggle_test();
        bit pat[6];
        int k;
        logic [DW-1:0] a_sent, b_sent;
        pat = '{1, 0, 1, 1, 0, 1};
        k = 0;
        mem_ready = 1; px_valid = 0;
        drw_req = 1; drw_base = 10; drw_len = 4;
        wait_ack(1, "toggle");
        drw_req = 0;
        for (int i = 0; i < 6; i++) begin
            px_valid = pat[i];
            px_a = DW'($urandom); px_b = DW'($urandom);
            a_sent = px_a; b_sent = px_b;
            @(negedge clk);
            check($sformatf("toggle we %0d", i), 32'(mem_we), 32'(pat[i]));
            check($sformatf("toggle addr_a %0d", i), 32'(mem_addr_a), 20 + 2 * k);
            if (mem_we) begin
                check("toggle din_a", 32'(mem_din_a), 32'(a_sent));
                check("toggle din_b", 32'(mem_din_b), 32'(b_sent));
                check("toggle px_ready", 32'(px_ready), 1);
                k++;
            end
            tick();
        end
        px_valid = 0;
        @(negedge clk);
        check("toggle done", 32'(done), 1);
        check("toggle done_src", 32'(done_src), 1);
        check("toggle writes", k, 4);
        tick();
        px_valid = 1;
    endtask

    task automatic tie_test();
        int exp_draw[4];
        bit got, is_d, dgot, src, clp;
        int t_prev_done, n, fa, la, t_done;
        exp_draw = '{0, 1, 0, 1};
        reset = 1; tick(); reset = 0;
        mem_ready = 1; px_valid = 1;
        clr_req = 1; clr_base = 100; clr_len = 2;
        drw_req = 1; drw_base = 200; drw_len = 3;
        t_prev_done = -1;
        for (int g = 0; g < 4; g++) begin
            wait_any_ack(got, is_d);
            check($sformatf("tie grant%0d seen", g), 32'(got), 1);
            check($sformatf("tie grant%0d src", g), 32'(is_d), exp_draw[g]);
            check($sformatf("tie grant%0d after done", g), 32'(t_ack > t_prev_done), 1);
            if (is_d) drw_req = 0; else clr_req = 0;
            drain(30, n, fa, la, dgot, t_done, src, clp);
            check($sformatf("tie job%0d done", g), 32'(dgot), 1);
            t_prev_done = t_done;
            if (g == 0) clr_req = 1;
            if (g == 1) drw_req = 1;
        end
        clr_req = 0; drw_req = 0;
    endtask

    task automatic stall_test();
        int n, fa, la, t_done;
        bit got, src, clp;
        mem_ready = 1;
        clr_req = 1; clr_base = 100; clr_len = 6;
        wait_ack(0, "stall");
        clr_req = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall pre we", 32'(mem_we), 1);
            tick();
        end
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall we", 32'(mem_we), 0);
            check("stall addr_a held", 32'(mem_addr_a), 204);
            check("stall busy", 32'(busy), 1);
            tick();
        end
        mem_ready = 1;
        drain(30, n, fa, la, got, t_done, src, clp);
        check("stall done seen", 32'(got), 1);
        check("stall rest writes", n, 4);
        check("stall rest first a", fa, 204);
        check("stall rest last a", la, 210);
    endtask

    task automatic reset_mid_test();
        int n, nd, nw;
        mem_ready = 1; px_valid = 1;
        drw_req = 1; drw_base = 1000; drw_len = 20;
        wait_ack(1, "rstmid");
        drw_req = 0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_we) n++;
            tick();
        end
        check("rstmid beats before reset", n, 5);
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check("rstmid busy", 32'(busy), 0);
        check("rstmid we", 32'(mem_we), 0);
        check("rstmid done", 32'(done), 0);
        tick();
        nd = 0; nw = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (mem_we) nw++;
            tick();
        end
        check("rstmid later done", nd, 0);
        check("rstmid later writes", nw, 0);
    endtask

    function automatic logic [PW-1:0] rand_base();
        if ($urandom_range(0, 1) == 0) return PW'($urandom_range(0, PN - 1));
        return PW'(PN - int'($urandom_range(1, 24)));
    endfunction

    function automatic logic [PW-1:0] rand_len();
        if ($urandom_range(0, 39) == 0) return PW'($urandom_range(0, PN - 1));
        return PW'($urandom_range(0, 24));
    endfunction

    task automatic random_test();
        bit ca, da;
        ca = 0; da = 0;
        for (int c = 0; c < 4000; c++) begin
            if (ca) clr_req = 0;
            if (da) drw_req = 0;
            if (!clr_req && $urandom_range(0, 5) == 0) begin
                clr_req = 1; clr_base = rand_base(); clr_len = rand_len();
            end
            if (!drw_req && $urandom_range(0, 5) == 0) begin
                drw_req = 1; drw_base = rand_base(); drw_len = rand_len();
            end
            px_valid  = ($urandom_range(0, 3) != 0);
            px_a      = DW'($urandom);
            px_b      = DW'($urandom);
            mem_ready = ($urandom_range(0, 4) != 0);
            reset     = ($urandom_range(0, 399) == 0);
            @(negedge clk);
            ca = clr_ack;
            da = drw_ack;
            tick();
        end
        reset = 0; clr_req = 0; drw_req = 0;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        //          draw base  len   n     clip first  last
        vecs[0] = '{0, 3968, 64,   64,   0, 7936,  8062};
        vecs[1] = '{1, 8190, 5,    2,    1, 16380, 16382};
        vecs[2] = '{0, 5,    0,    0,    0, -1,    -1};
        vecs[3] = '{1, 10,   4,    4,    0, 20,    26};
        vecs[4] = '{0, 8191, 1,    1,    0, 16382, 16382};
        vecs[5] = '{0, 8191, 2,    1,    1, 16382, 16382};
        vecs[6] = '{1, 0,    3,    3,    0, 0,     4};
        vecs[7] = '{0, 4000, 8191, 4192, 1, 8000,  16382};
        vecs[8] = '{1, 8000, 192,  192,  0, 16000, 16382};

        reset = 1;
        clr_req = 0; clr_base = 0; clr_len = 0;
        drw_req = 0; drw_base = 0; drw_len = 0;
        px_valid = 0; px_a = 0; px_b = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset busy",   32'(busy),       0);
        check("reset we",     32'(mem_we),     0);
        check("reset addr_a", 32'(mem_addr_a), 0);
        check("reset addr_b", 32'(mem_addr_b), 1);
        check("reset done",   32'(done),       0);
        tick();
        reset = 0;
        @(negedge clk);
        check("idle busy",   32'(busy),       0);
        check("idle addr_b", 32'(mem_addr_b), 1);
        tick();

        mem_ready = 1; px_valid = 1;
        for (int i = 0; i < 9; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        toggle_test();
        tie_test();
        stall_test();
        reset_mid_test();
        random_test();

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
